mux_operand_loader: RTL and testbench
=====================================

Name: mux_operand_loader

Overview:
- Upstream stage of the 2:1 operand mux (`mux`, ports A, B, S, X).
- Accepts a serial stream of W-bit words over a valid/ready handshake and assembles them into one operand set {A, B, S}.
- Holds that set stable on its outputs, flagged by out_valid, until the consumer accepts it.
- Lets the combinational mux be fed from a sequenced, back-pressured source instead of free-running stimulus.

Parameters:
- W, 4, width of operands A and B and of the input word.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  W  serial operand word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader can accept a word this cycle.
- flush  input  1  synchronous abort of the current operand set.
- out_a  output  W  operand A, drives mux A.
- out_b  output  W  operand B, drives mux B.
- out_s  output  1  select, drives mux S.
- out_valid  output  1  {out_a, out_b, out_s} is a complete set.
- out_ready  input  1  consumer accepts the set this cycle.

Behaviour:
- Reset: one clock, clk; rst is asynchronous and active-high. While rst=1: state=IDLE, out_a=0, out_b=0, out_s=0, out_valid=0, in_ready=0 (and txn_count=0 if enabled). Reset mid-sequence discards any partial set.
- All outputs are registered. in_ready and out_valid are decoded from the state register only and never depend combinationally on inputs.
- In-transfer: occurs on a rising edge with in_valid=1 and in_ready=1.
- Out-transfer: occurs on a rising edge with out_valid=1 and out_ready=1.
- IDLE: in_ready=0, out_valid=0. Moves to LOAD_A on the next edge unconditionally, so in_ready first rises one cycle after rst deasserts.
- LOAD_A: in_ready=1. On in-transfer, out_a<=in_data and go to LOAD_B.
- LOAD_B: in_ready=1. On in-transfer, out_b<=in_data and go to LOAD_S.
- LOAD_S: in_ready=1. On in-transfer, out_s<=in_data[0] (upper bits ignored) and go to PRESENT.
- PRESENT: in_ready=0, out_valid=1.
  - out_a, out_b and out_s are held constant while out_ready=0.
  - On out-transfer, go to LOAD_A; out_valid falls the next cycle.
- No bypass: a new word cannot be accepted in the same cycle the set is presented. Minimum period is 4 cycles per set (3 loads + 1 present).
- Operand registers keep their old values while the next set is loading. Consumers must qualify on out_valid.
- flush=1 at an edge: go to LOAD_A from any non-IDLE state.
  - out_valid drops next cycle; operand registers are unchanged.
  - A simultaneous in-transfer is discarded.
  - A simultaneous out-transfer does not count as completed.
  - flush has no effect in IDLE.
- in_valid is ignored while in_ready=0. No data is latched in IDLE or PRESENT.

Optional Feature:
- Macro MUX_LOADER_CNT_EN.
- Defined:
  - Adds output port txn_count, 8 bits, registered, reset 0.
  - Increments by 1 on each out-transfer not coincident with flush.
  - Wraps 255 -> 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then stream 0x3, 0xA, 0x0 with in_valid held 1 and out_ready=1 -> in_ready high from cycle 1 after reset; out_a=3, out_b=A, out_s=0 with out_valid=1 for exactly one cycle; the attached mux gives X=3.
- Same stream with final word 0xF (S=1), out_ready held 0 for 5 cycles -> out_valid=1 and outputs stable for 6 cycles, in_ready=0 throughout; X=A; after accept, in_ready=1 the next cycle.
- Gaps: in_valid toggles 1,0,0,1,0,1 carrying 0x5, 0x6, 0x1 -> only valid-cycle words are latched; out_a=5, out_b=6, out_s=1.
- flush asserted in the cycle the LOAD_B word 0x7 is offered -> word dropped, state returns to LOAD_A; the next words 0x1, 0x2, 0x0 give out_a=1, out_b=2, out_s=0.
- rst pulsed while in PRESENT with out_a=9 -> outputs immediately 0, out_valid=0, in_ready=0; normal loading resumes after release.
- With MUX_LOADER_CNT_EN: 257 back-to-back sets -> txn_count=1; a flush coincident with out-transfer does not increment.

Source files
------------

// File: rtl/mux_operand_loader_if.sv
// Handshake bundle between the serial word source, the operand loader and
// the downstream 2:1 operand mux. The loader connects through the slave
// modport; the word producer / operand consumer side uses master.
interface mux_operand_loader_if #(
    parameter int W = 4
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         out_s;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_a, out_b, out_s, out_valid
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_a, out_b, out_s, out_valid
    );
endinterface

// File: rtl/mux_operand_loader.sv
// Operand loader for the 2:1 operand mux: collects three serial words
// (A, B, then S in bit 0) over a valid/ready handshake and presents them as
// one registered operand set until the consumer accepts it.
// Optional feature macro: MUX_LOADER_CNT_EN adds an 8-bit wrapping count of
// completed out-transfers on port txn_count.
module mux_operand_loader #(
    parameter int W = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux_operand_loader_if.slave bus
`ifdef MUX_LOADER_CNT_EN
    ,
    output logic [7:0]          txn_count
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        LOAD_S  = 3'd3,
        PRESENT = 3'd4
    } state_t;

    state_t       state_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         s_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic [7:0]   cnt_q;

    logic in_xfer;
    logic out_xfer;

    // Handshake qualifiers use only registered flags, so no combinational
    // path exists from inputs to in_ready/out_valid.
    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = out_valid_q & bus.out_ready;

    // Sequencer: state, registered handshake flags, operand registers and
    // the transfer counter all advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= 8'd0;
        end else if (state_q == IDLE) begin
            // Single settling cycle after reset; flush is ignored here.
            state_q    <= LOAD_A;
            in_ready_q <= 1'b1;
        end else if (bus.flush) begin
            // Abort: partial words and any coincident transfer are dropped,
            // operand registers keep their last values.
            state_q     <= LOAD_A;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (in_xfer) begin
                        a_q     <= bus.in_data;
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_xfer) begin
                        b_q     <= bus.in_data;
                        state_q <= LOAD_S;
                    end
                end
                LOAD_S: begin
                    if (in_xfer) begin
                        s_q         <= bus.in_data[0];
                        state_q     <= PRESENT;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (out_xfer) begin
                        state_q     <= LOAD_A;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        cnt_q       <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_s     = s_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;

`ifdef MUX_LOADER_CNT_EN
    assign txn_count = cnt_q;
`else
    // Counter has no observer in this build; tie it off as unused.
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_mux_operand_loader.sv
// Self-checking bench for mux_operand_loader: directed scenarios followed by
// randomized traffic, all compared against a word-list reference model.
module tb_mux_operand_loader;

    localparam int W = 4;

    logic clk;
    logic rst;

    mux_operand_loader_if #(.W(W)) bus ();

`ifdef MUX_LOADER_CNT_EN
    logic [7:0] txn_count;
    mux_operand_loader #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .txn_count (txn_count)
    );
`else
    mux_operand_loader #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a loader is "started" one edge after reset, gathers
    // words into a list, and presents the set once three words are held.
    bit         m_started;
    logic [W-1:0] m_words[$];
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic         m_s;
    int           m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_words.delete();
        m_a   = '0;
        m_b   = '0;
        m_s   = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_edge(input bit iv, input logic [W-1:0] d, input bit fl, input bit ordy);
        if (!m_started) begin
            m_started = 1'b1;
        end else if (fl) begin
            m_words.delete();
        end else if (m_words.size() == 3) begin
            if (ordy) begin
                m_words.delete();
                m_cnt = (m_cnt + 1) % 256;
            end
        end else if (iv) begin
            m_words.push_back(d);
            if (m_words.size() == 1) m_a = d;
            else if (m_words.size() == 2) m_b = d;
            else m_s = d[0];
        end
    endtask

    task automatic check_all();
        logic [W-1:0] x_dut;
        logic [W-1:0] x_exp;
        chk("in_ready", 32'(bus.in_ready), 32'(m_started && m_words.size() < 3));
        chk("out_valid", 32'(bus.out_valid), 32'(m_words.size() == 3));
        chk("out_a", 32'(bus.out_a), 32'(m_a));
        chk("out_b", 32'(bus.out_b), 32'(m_b));
        chk("out_s", 32'(bus.out_s), 32'(m_s));
        x_dut = bus.out_s ? bus.out_b : bus.out_a;
        x_exp = m_s ? m_b : m_a;
        if (m_words.size() == 3) chk("mux_x", 32'(x_dut), 32'(x_exp));
`ifdef MUX_LOADER_CNT_EN
        chk("txn_count", 32'(txn_count), 32'(m_cnt));
`endif
    endtask

    // One clock: drive inputs (we sit #1 after a rising edge), take the edge,
    // advance the model and compare.
    task automatic cycle(input bit iv, input logic [W-1:0] d, input bit fl, input bit ordy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.flush     = fl;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
        model_edge(iv, d, fl, ordy);
        check_all();
    endtask

    // Asynchronous reset pulse placed mid-cycle, held across one edge.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Basic stream 3, A, 0 with consumer always ready.
        cycle(0, 4'h0, 0, 1);
        cycle(1, 4'h3, 0, 1);
        cycle(1, 4'hA, 0, 1);
        cycle(1, 4'h0, 0, 1);
        chk("t1_x", 32'(bus.out_s ? bus.out_b : bus.out_a), 32'h3);
        cycle(1, 4'h0, 0, 1);
        chk("t1_valid_one_cycle", 32'(bus.out_valid), 32'h0);

        // Back-pressure: S=1, consumer stalls 5 cycles.
        cycle(1, 4'h3, 0, 0);
        cycle(1, 4'hA, 0, 0);
        cycle(1, 4'hF, 0, 0);
        repeat (5) cycle(1, 4'h7, 0, 0);
        chk("t2_x", 32'(bus.out_s ? bus.out_b : bus.out_a), 32'hA);
        cycle(0, 4'h0, 0, 1);
        chk("t2_ready_after_accept", 32'(bus.in_ready), 32'h1);

        // Gaps in in_valid.
        cycle(1, 4'h5, 0, 0);
        cycle(0, 4'h9, 0, 0);
        cycle(0, 4'h9, 0, 0);
        cycle(1, 4'h6, 0, 0);
        cycle(0, 4'h9, 0, 0);
        cycle(1, 4'h1, 0, 0);
        chk("t3_a", 32'(bus.out_a), 32'h5);
        chk("t3_b", 32'(bus.out_b), 32'h6);
        chk("t3_s", 32'(bus.out_s), 32'h1);
        cycle(0, 4'h0, 0, 1);

        // Flush while the B word is offered.
        cycle(1, 4'h8, 0, 0);
        cycle(1, 4'h7, 1, 0);
        cycle(1, 4'h1, 0, 0);
        cycle(1, 4'h2, 0, 0);
        cycle(1, 4'h0, 0, 0);
        chk("t4_a", 32'(bus.out_a), 32'h1);
        chk("t4_b", 32'(bus.out_b), 32'h2);
        chk("t4_s", 32'(bus.out_s), 32'h0);

        // Reset while presenting A=9.
        cycle(0, 4'h0, 0, 1);
        cycle(1, 4'h9, 0, 0);
        cycle(1, 4'h4, 0, 0);
        cycle(1, 4'h1, 0, 0);
        rst = 1'b1;
        #1;
        chk("t5_a_async", 32'(bus.out_a), 32'h0);
        chk("t5_valid_async", 32'(bus.out_valid), 32'h0);
        rst = 1'b0;
        pulse_reset();
        cycle(0, 4'h0, 0, 0);
        cycle(1, 4'hC, 0, 0);
        cycle(1, 4'hD, 0, 0);
        cycle(1, 4'h0, 0, 1);
        cycle(0, 4'h0, 0, 1);

`ifdef MUX_LOADER_CNT_EN
        // 257 back-to-back sets wrap the counter to 1.
        pulse_reset();
        cycle(0, 4'h0, 0, 1);
        for (int i = 0; i < 257; i++) begin
            cycle(1, 4'(i), 0, 1);
            cycle(1, 4'(i + 1), 0, 1);
            cycle(1, 4'(i + 2), 0, 1);
            cycle(0, 4'h0, 0, 1);
        end
        chk("cnt_wrap", 32'(txn_count), 32'h1);
        cycle(1, 4'h1, 0, 1);
        cycle(1, 4'h2, 0, 1);
        cycle(1, 4'h3, 0, 1);
        cycle(0, 4'h0, 1, 1);
        chk("cnt_flush_no_inc", 32'(txn_count), 32'h1);
`endif

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                cycle(bit'($urandom_range(0, 1)), 4'($urandom),
                      $urandom_range(0, 9) == 0, bit'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
